// File: rtl/fast_feed_arbiter_if.sv
// rtl/fast_feed_arbiter_if.sv - feed-channel and parser byte-port bundle for the fast feed arbiter
interface fast_feed_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH*8-1:0] ch_data;
  logic [NUM_CH-1:0]   ch_valid;
  logic [NUM_CH-1:0]   ch_last;
  logic [NUM_CH-1:0]   ch_ready;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;
  logic [CH_W-1:0]     out_ch_id;

  modport master (
    input  ch_data, ch_valid, ch_last, out_ready,
    output ch_ready, out_data, out_valid, out_last, out_ch_id
  );

  modport slave (
    output ch_data, ch_valid, ch_last, out_ready,
    input  ch_ready, out_data, out_valid, out_last, out_ch_id
  );
endinterface

// File: rtl/fast_feed_arbiter.sv
// rtl/fast_feed_arbiter.sv - message-atomic round-robin arbiter of UDP feed bytes onto one parser port
// A watchdog aborts a locked message that stops moving so a dead feed cannot starve the rest.
module fast_feed_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  fast_feed_arbiter_if.master bus,
  input  logic [NUM_CH-1:0]   ch_enable_i,
  output logic                out_abort_o,
  output logic                busy_o,
  output logic [31:0]         msg_count_o,
  output logic [31:0]         timeout_count_o
);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_id_q, ch_id_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              abort_q, abort_d;
  logic              busy_q, busy_d;
  logic [31:0]       msg_cnt_q, msg_cnt_d;
  logic [31:0]       tmo_cnt_q, tmo_cnt_d;

  logic [NUM_CH-1:0] req;
  logic              req_any;
  logic [CH_W-1:0]   winner;
  logic              xfer;
  int                idx;

  assign req = bus.ch_valid & ch_enable_i;

  // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
  always_comb begin
    winner  = '0;
    req_any = 1'b0;
    idx     = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_CH;
      if (req[idx]) begin
        winner  = CH_W'(idx);
        req_any = 1'b1;
      end
    end
  end

  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.ch_ready  = '0;
    if (state_q == XFER) begin
      bus.out_data           = bus.ch_data[int'(ch_id_q)*8 +: 8];
      bus.out_valid          = bus.ch_valid[ch_id_q];
      bus.out_last           = bus.ch_last[ch_id_q];
      bus.ch_ready[ch_id_q]  = bus.out_ready;
    end
  end

  assign xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    ch_id_d      = ch_id_q;
    last_grant_d = last_grant_q;
    idle_cnt_d   = idle_cnt_q;
    abort_d      = 1'b0;
    busy_d       = busy_q;
    msg_cnt_d    = msg_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          ch_id_d    = winner;
          busy_d     = 1'b1;
          idle_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        // A transfer in the timeout cycle takes precedence over the abort.
        if (xfer) begin
          idle_cnt_d = '0;
          if (bus.out_last) begin
            msg_cnt_d    = msg_cnt_q + 32'd1;
            last_grant_d = ch_id_q;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
          abort_d      = 1'b1;
          tmo_cnt_d    = tmo_cnt_q + 32'd1;
          last_grant_d = ch_id_q;
          busy_d       = 1'b0;
          idle_cnt_d   = '0;
          state_d      = IDLE;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ch_id_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      idle_cnt_q   <= '0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      msg_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_id_q      <= ch_id_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      msg_cnt_q    <= msg_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign bus.out_ch_id   = ch_id_q;
  assign out_abort_o     = abort_q;
  assign busy_o          = busy_q;
  assign msg_count_o     = msg_cnt_q;
  assign timeout_count_o = tmo_cnt_q;
endmodule

// File: tb/tb_fast_feed_arbiter.sv
// tb/tb_fast_feed_arbiter.sv - scoreboard bench for fast_feed_arbiter
module tb_fast_feed_arbiter;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_enable;
  logic              out_abort;
  logic              busy;
  logic [31:0]       msg_count;
  logic [31:0]       timeout_count;

  fast_feed_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  fast_feed_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TIMEOUT_CYC(TMO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .ch_enable_i     (ch_enable),
    .out_abort_o     (out_abort),
    .busy_o          (busy),
    .msg_count_o     (msg_count),
    .timeout_count_o (timeout_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0]        src_q [NUM_CH][$];
  logic [8:0]        exp_q [NUM_CH][$];
  logic [NUM_CH-1:0] acc = '0;
  int                grant_q[$];
  int                xfer_cyc_q[$];
  int                abort_n = 0;
  int                abort_cyc = 0;
  logic              abort_busy = 1'b0;
  int                fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NUM_CH; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic push_byte(input int ch, input logic last, input logic [7:0] d);
    src_q[ch].push_back({last, d});
    exp_q[ch].push_back({last, d});
  endtask

  task automatic push_msg(input int ch, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) push_byte(ch, j == n - 1, base + 8'(j));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((pending() > 0 || busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, pending(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Channel sources: retire the byte accepted in the previous cycle, present the next one.
  initial begin
    bus.ch_valid = '0;
    bus.ch_data  = '0;
    bus.ch_last  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          bus.ch_valid[i]      = 1'b1;
          bus.ch_data[8*i +: 8] = src_q[i][0][7:0];
          bus.ch_last[i]       = src_q[i][0][8];
        end else begin
          bus.ch_valid[i]      = 1'b0;
          bus.ch_data[8*i +: 8] = 8'h00;
          bus.ch_last[i]       = 1'b0;
        end
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic       prev_busy;
    logic [8:0] e;
    int         sel;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      acc = bus.ch_valid & bus.ch_ready;
      if (rst === 1'b0) begin
        sel = int'(bus.out_ch_id);
        chk("ch_ready", {28'd0, bus.ch_ready},
            busy ? (32'(bus.out_ready) << sel) : 32'd0);
        chk("out_valid", bus.out_valid, busy ? bus.ch_valid[sel] : 1'b0);
        if (busy === 1'b1 && prev_busy !== 1'b1) grant_q.push_back(sel);
        if (busy !== 1'b1 && prev_busy === 1'b1) fall_cyc = cyc;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_q[sel].size() == 0) begin
            chk("extra_byte", 0, 1);
          end else begin
            e = exp_q[sel].pop_front();
            chk($sformatf("byte_ch%0d", sel), {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
          end
          xfer_cyc_q.push_back(cyc);
        end
        if (out_abort === 1'b1) begin
          abort_n++;
          abort_cyc  = cyc;
          abort_busy = busy;
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    int g0, x0, a0, p, m0;
    int busy_seen;
    int exp_order[5];
    rst           = 1'b1;
    ch_enable     = '1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ch_id", bus.out_ch_id, 0);
    chk("rst_abort", out_abort, 0);
    chk("rst_msg", msg_count, 0);
    chk("rst_tmo", timeout_count, 0);

    // 1: single 3-byte message on ch0
    g0 = grant_q.size(); x0 = xfer_cyc_q.size();
    push_byte(0, 1'b0, 8'h11);
    push_byte(0, 1'b0, 8'h22);
    push_byte(0, 1'b1, 8'h33);
    p = cyc;
    wait_drain("t1_drain", 50);
    chk("t1_latency", qat(xfer_cyc_q, x0), p + 2);
    chk("t1_back2back", qat(xfer_cyc_q, x0 + 2) - qat(xfer_cyc_q, x0), 2);
    chk("t1_grant", qat(grant_q, g0), 0);
    chk("t1_msg", msg_count, 1);
    chk("t1_busy_fall", fall_cyc, qat(xfer_cyc_q, x0 + 2) + 1);

    // 2: all channels busy, round-robin with one bubble between messages
    do_reset();
    @(negedge clk);
    chk("t2_rst_msg", msg_count, 0);
    g0 = grant_q.size(); x0 = xfer_cyc_q.size();
    push_msg(0, 2, 8'hA0);
    push_msg(1, 2, 8'hB0);
    push_msg(2, 2, 8'hC0);
    push_msg(3, 2, 8'hD0);
    push_msg(0, 2, 8'hA8);
    wait_drain("t2_drain", 100);
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_grant%0d", k), qat(grant_q, g0 + k), exp_order[k]);
    for (int k = 1; k < 10; k++)
      chk($sformatf("t2_gap%0d", k),
          qat(xfer_cyc_q, x0 + k) - qat(xfer_cyc_q, x0 + k - 1), (k % 2 == 1) ? 1 : 2);
    chk("t2_msg", msg_count, 5);

    // 3: ch1 stalls after one byte and is aborted by the watchdog
    g0 = grant_q.size(); x0 = xfer_cyc_q.size(); a0 = abort_n;
    push_byte(1, 1'b0, 8'h55);
    wait_busy("t3_lock", 20);
    push_msg(2, 2, 8'h60);
    wait_drain("t3_drain", 100);
    chk("t3_abort_n", abort_n - a0, 1);
    chk("t3_abort_at", abort_cyc - qat(xfer_cyc_q, x0), TMO + 1);
    chk("t3_abort_busy", abort_busy, 0);
    chk("t3_tmo", timeout_count, 1);
    chk("t3_grant0", qat(grant_q, g0), 1);
    chk("t3_grant1", qat(grant_q, g0 + 1), 2);
    chk("t3_msg", msg_count, 6);

    // 4: parser back-pressure while ch1 is locked and ch2 waits
    g0 = grant_q.size();
    push_msg(1, 4, 8'h70);
    wait_busy("t4_lock", 20);
    chk("t4_ch_id", bus.out_ch_id, 1);
    push_msg(2, 2, 8'h80);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_hold%0d", k), {23'd0, bus.out_valid, bus.out_data}, {23'd1, 8'h71});
      chk($sformatf("t4_ch2_rdy%0d", k), bus.ch_ready[2], 0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain("t4_drain", 100);
    chk("t4_grant0", qat(grant_q, g0), 1);
    chk("t4_grant1", qat(grant_q, g0 + 1), 2);
    chk("t4_msg", msg_count, 8);

    // 5: disabled channel is never granted; disabling a locked channel keeps the lock
    @(posedge clk); #1 ch_enable = 4'b1101;
    m0 = int'(msg_count);
    push_msg(1, 2, 8'h90);
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen++;
    end
    chk("t5_ch1_blocked", busy_seen, 0);
    chk("t5_msg_hold", msg_count, m0);
    src_q[1].delete();
    exp_q[1].delete();
    g0 = grant_q.size();
    push_msg(0, 4, 8'hE0);
    wait_busy("t5_lock", 20);
    chk("t5_ch_id", bus.out_ch_id, 0);
    @(posedge clk); #1 ch_enable = 4'b1100;
    wait_drain("t5_drain", 100);
    chk("t5_msg", msg_count, m0 + 1);
    chk("t5_grant", grant_q.size() - g0, 1);
    @(posedge clk); #1 ch_enable = '1;

    // 6: reset in the middle of a ch3 message
    push_msg(3, 6, 8'hF0);
    wait_busy("t6_lock", 20);
    chk("t6_ch_id", bus.out_ch_id, 3);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    push_msg(0, 2, 8'h40);
    repeat (2) @(negedge clk);
    g0 = grant_q.size();
    do_reset();
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_msg", msg_count, 0);
    chk("t6_tmo", timeout_count, 0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain("t6_drain", 100);
    chk("t6_grant0", qat(grant_q, g0), 0);
    chk("t6_grant1", qat(grant_q, g0 + 1), 3);
    chk("t6_msg_end", msg_count, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
